// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory with core load/store port and host req/ack port
//
// Purpose:
//   Word-organised data memory. Core loads are combinational, with lane
//   extraction and sign/zero extension selected by func3. Core stores commit
//   at posedge with byte enables. A host port (req/ack) preloads and inspects
//   words. It yields to core stores in the same cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   dmem_addr           core byte address
//   dmem_dataOUT        core store data (low bits significant for SB/SH)
//   func3_MEM           000 B, 001 H, 010 W, 100 BU, 101 HU
//   memW_en_MEM         core store enable
//   dmem_dataIN         core load data (combinational)
//   host_req/host_we    host request, 1 = word write / 0 = word read
//   host_addr           host byte address (bits [1:0] ignored)
//   host_wdata          host write data
//   host_ack            one-cycle completion pulse
//   host_rdata          host read data, valid while host_ack = 1
//   misalign_err        sticky misaligned-store flag
//   tohost/tohost_valid tohost register and write pulse
//
// Optional feature macro: DMEM_TOHOST_EN
//   Defined: a core SW to TOHOST_ADDR loads tohost instead of the array, and
//   core reads of TOHOST_ADDR return tohost. Undefined: TOHOST_ADDR is plain
//   memory and tohost/tohost_valid are tied to 0.

module dmem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          AW          = $clog2(DEPTH_WORDS),
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_dataOUT,
    input  logic [2:0]  func3_MEM,
    input  logic        memW_en_MEM,
    output logic [31:0] dmem_dataIN,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_ack,
    output logic [31:0] host_rdata,
    output logic        misalign_err,
    output logic [31:0] tohost,
    output logic        tohost_valid
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [0:0]    r_state;
    logic [31:0]   r_host_rdata;
    logic          r_misalign;

    logic [AW-1:0] w_core_idx;
    logic [AW-1:0] w_host_idx;
    logic          w_is_byte;
    logic          w_is_half;
    logic          w_misalign;
    logic          w_tohost_hit;
    logic          w_core_we;
    logic          w_host_go;
    logic          w_host_we;
    logic [3:0]    w_core_be;
    logic [31:0]   w_core_wdata;
    logic [31:0]   w_rd_word;
    logic [7:0]    w_rd_byte;
    logic [15:0]   w_rd_half;
    logic          w_unused;

    // Address bits above the array and the host byte offset carry no meaning.
    assign w_unused = ^{dmem_addr[31:AW+2], host_addr[31:AW+2], host_addr[1:0], TOHOST_ADDR};

    assign w_core_idx = dmem_addr[AW+1:2];
    assign w_host_idx = host_addr[AW+1:2];

    // Store size from func3[1:0]; anything that is not B or H is a word store.
    assign w_is_byte = (func3_MEM[1:0] == 2'b00);
    assign w_is_half = (func3_MEM[1:0] == 2'b01);

    // Only stores are checked: func3 carries no meaning on non-load cycles.
    assign w_misalign = memW_en_MEM &&
                        ((w_is_half && dmem_addr[0]) ||
                         (!w_is_byte && !w_is_half && (dmem_addr[1:0] != 2'b00)));

`ifdef DMEM_TOHOST_EN
    logic [31:0] r_tohost;
    logic        r_tohost_valid;

    assign w_tohost_hit = memW_en_MEM && (func3_MEM == 3'b010) && (dmem_addr == TOHOST_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tohost       <= 32'h0;
            r_tohost_valid <= 1'b0;
        end else begin
            r_tohost_valid <= w_tohost_hit;
            if (w_tohost_hit) begin
                r_tohost <= dmem_dataOUT;
            end
        end
    end

    assign tohost       = r_tohost;
    assign tohost_valid = r_tohost_valid;
    assign w_rd_word    = (dmem_addr == TOHOST_ADDR) ? r_tohost : r_mem[w_core_idx];
`else
    assign w_tohost_hit = 1'b0;
    assign tohost       = 32'h0;
    assign tohost_valid = 1'b0;
    assign w_rd_word    = r_mem[w_core_idx];
`endif

    assign w_core_we = memW_en_MEM && !w_misalign && !w_tohost_hit;

    // Any core store, even a suppressed one, takes the cycle from the host.
    assign w_host_go = (r_state == ST_IDLE) && host_req && !memW_en_MEM;
    assign w_host_we = w_host_go && host_we;

    // Replicate the store lane across the word so the byte enables alone
    // select where it lands.
    always_comb begin
        w_core_be    = 4'b1111;
        w_core_wdata = dmem_dataOUT;
        if (w_is_byte) begin
            w_core_be    = 4'b0001 << dmem_addr[1:0];
            w_core_wdata = {4{dmem_dataOUT[7:0]}};
        end else if (w_is_half) begin
            w_core_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
            w_core_wdata = {2{dmem_dataOUT[15:0]}};
        end
    end

    // The array has no reset.
    always_ff @(posedge clk) begin
        if (w_core_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_core_be[b]) begin
                    r_mem[w_core_idx][b*8 +: 8] <= w_core_wdata[b*8 +: 8];
                end
            end
        end else if (w_host_we) begin
            r_mem[w_host_idx] <= host_wdata;
        end
    end

    always_comb begin
        case (dmem_addr[1:0])
            2'd0:    w_rd_byte = w_rd_word[7:0];
            2'd1:    w_rd_byte = w_rd_word[15:8];
            2'd2:    w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
        w_rd_half = dmem_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    end

    always_comb begin
        case (func3_MEM)
            3'b000:  dmem_dataIN = {{24{w_rd_byte[7]}}, w_rd_byte};
            3'b001:  dmem_dataIN = {{16{w_rd_half[15]}}, w_rd_half};
            3'b100:  dmem_dataIN = {24'h0, w_rd_byte};
            3'b101:  dmem_dataIN = {16'h0, w_rd_half};
            default: dmem_dataIN = w_rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_host_rdata <= 32'h0;
            r_misalign   <= 1'b0;
        end else begin
            if (w_misalign) begin
                r_misalign <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_host_go) begin
                        r_state <= ST_ACK;
                        if (!host_we) begin
                            r_host_rdata <= r_mem[w_host_idx];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign host_ack     = (r_state == ST_ACK);
    assign host_rdata   = r_host_rdata;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder

module tb_dmem_responder;

    localparam logic [31:0] TOHOST = 32'h0000_FFF0;
`ifdef DMEM_TOHOST_EN
    localparam bit TOHOST_EN = 1'b1;
`else
    localparam bit TOHOST_EN = 1'b0;
`endif

    typedef struct {
        logic        rd;
        logic [31:0] d;
    } hexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_dataOUT;
    logic [2:0]  func3_MEM;
    logic        memW_en_MEM;
    logic [31:0] dmem_dataIN;
    logic        host_req;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        misalign_err;
    logic [31:0] tohost;
    logic        tohost_valid;

    int          n_chk = 0;
    int          n_err = 0;
    hexp_t       exp_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] mdl [int];
    logic [31:0] mdl_tohost = 32'h0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_addr    (dmem_addr),
        .dmem_dataOUT (dmem_dataOUT),
        .func3_MEM    (func3_MEM),
        .memW_en_MEM  (memW_en_MEM),
        .dmem_dataIN  (dmem_dataIN),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .misalign_err (misalign_err),
        .tohost       (tohost),
        .tohost_valid (tohost_valid)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = (TOHOST_EN && a == TOHOST) ? mdl_tohost : mdl[widx(a)];
        b = w[a[1:0]*8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic void mdl_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        if (TOHOST_EN && f3 == 3'b010 && a == TOHOST) begin
            mdl_tohost = d;
            return;
        end
        if ((f3[1:0] == 2'b01 && a[0]) || (f3[1] && a[1:0] != 2'b00)) return;
        w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
        case (f3[1:0])
            2'b00:   w[a[1:0]*8 +: 8] = d[7:0];
            2'b01:   if (a[1]) w[31:16] = d[15:0]; else w[15:0] = d[15:0];
            default: w = d;
        endcase
        mdl[widx(a)] = w;
    endfunction

    // Host completions are scored at the negedge of the single ack cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && host_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("host_ack_unexpected", {31'h0, host_ack}, 32'h0);
            end else begin
                hexp_t e;
                e = exp_q.pop_front();
                if (e.rd) chk("host_rdata", host_rdata, e.d);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 one cycle after the ack.
    task automatic host_op(input logic we, input logic [31:0] a, input logic [31:0] d, output int lat);
        hexp_t e;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        e.rd = !we;
        e.d  = we ? 32'h0 : mdl[widx(a)];
        exp_q.push_back(e);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!host_ack && lat < 20);
        host_req = 1'b0;
        if (!host_ack) chk("host_ack_timeout", {31'h0, host_ack}, 32'h1);
        if (we) mdl[widx(a)] = d;
        @(posedge clk);
        #1;
    endtask

    task automatic core_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        memW_en_MEM = 1'b0;
        func3_MEM   = f3;
        dmem_addr   = a;
        ld_q.push_back(exp);
        #1;
        chk(tag, dmem_dataIN, ld_q.pop_front());
    endtask

    task automatic core_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        memW_en_MEM  = 1'b1;
        func3_MEM    = f3;
        dmem_addr    = a;
        dmem_dataOUT = d;
        mdl_store(f3, a, d);
        @(posedge clk);
        #1;
        memW_en_MEM = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [2:0]  f3s [5];
        logic [31:0] base;
        logic [31:0] a;
        logic [2:0]  f3;

        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1'b0;
        dmem_addr = 32'h0; dmem_dataOUT = 32'h0; func3_MEM = 3'b010; memW_en_MEM = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_host_ack", {31'h0, host_ack}, 32'h0);
        chk("rst_host_rdata", host_rdata, 32'h0);
        chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
        chk("rst_tohost", tohost, 32'h0);
        chk("rst_tohost_valid", {31'h0, tohost_valid}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        host_op(1'b1, 32'h10, 32'h8765_43A1, lat);
        chk("host_wr_lat", lat, 1);
        core_load("lw_10", 3'b010, 32'h10, 32'h8765_43A1);
        core_load("lb_10", 3'b000, 32'h10, 32'hFFFF_FFA1);
        core_load("lbu_13", 3'b100, 32'h13, 32'h0000_0087);
        core_load("lh_12", 3'b001, 32'h12, 32'hFFFF_8765);
        core_load("lhu_12", 3'b101, 32'h12, 32'h0000_8765);
        core_load("f3_011_word", 3'b011, 32'h13, 32'h8765_43A1);

        // SB: old byte visible in the store cycle, new byte one cycle later.
        @(posedge clk);
        #1;
        memW_en_MEM = 1'b1; func3_MEM = 3'b000; dmem_addr = 32'h11; dmem_dataOUT = 32'hFFFF_FF55;
        mdl_store(3'b000, 32'h11, 32'hFFFF_FF55);
        #1;
        chk("sb_same_cycle_old", dmem_dataIN, 32'h0000_0043);
        @(posedge clk);
        #1;
        core_load("sb_lw_after", 3'b010, 32'h10, 32'h8765_55A1);
        core_load("sb_lb_after", 3'b000, 32'h11, 32'h0000_0055);

        host_op(1'b1, 32'h20, 32'hCAFE_F00D, lat);
        chk("host_wr20_lat", lat, 1);

        // Host read contends with a core SW in the same cycle.
        begin
            hexp_t e;
            host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
            e.rd = 1'b1; e.d = 32'hCAFE_F00D;
            exp_q.push_back(e);
            memW_en_MEM = 1'b1; func3_MEM = 3'b010; dmem_addr = 32'h24; dmem_dataOUT = 32'h1122_3344;
            mdl_store(3'b010, 32'h24, 32'h1122_3344);
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                memW_en_MEM = 1'b0;
                lat++;
            end while (!host_ack && lat < 20);
            host_req = 1'b0;
            chk("contend_ack_lat", lat, 2);
            @(posedge clk);
            #1;
        end
        core_load("contend_core_wr", 3'b010, 32'h24, 32'h1122_3344);
        core_load("contend_word20", 3'b010, 32'h20, 32'hCAFE_F00D);

        // Misaligned stores are dropped and latch misalign_err.
        core_store(3'b010, 32'h22, 32'h0000_1234);
        chk("misalign_set", {31'h0, misalign_err}, 32'h1);
        core_load("misalign_sw_nowr", 3'b010, 32'h20, 32'hCAFE_F00D);
        core_store(3'b001, 32'h13, 32'h0000_BEEF);
        core_load("misalign_sh_nowr", 3'b010, 32'h10, 32'h8765_55A1);
        repeat (3) @(posedge clk);
        #1;
        chk("misalign_sticky", {31'h0, misalign_err}, 32'h1);

        // Random host writes, mixed loads, aligned sub-word stores.
        for (int i = 0; i < 8; i++) begin
            base = 32'h100 + 32'(i) * 4;
            host_op(1'b1, base, $urandom, lat);
            chk("rnd_wr_lat", lat, 1);
            for (int j = 0; j < 4; j++) begin
                f3 = f3s[$urandom_range(0, 4)];
                a  = base;
                if (f3[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
                else if (f3[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
                core_load("rnd_load", f3, a, ld_model(f3, a));
            end
            f3 = f3s[$urandom_range(0, 2)];
            a  = base;
            if (f3 == 3'b000) a[1:0] = 2'($urandom_range(0, 3));
            else if (f3 == 3'b001) a[1] = 1'($urandom_range(0, 1));
            core_store(f3, a, $urandom);
            core_load("rnd_store_lw", 3'b010, base, ld_model(3'b010, base));
            @(posedge clk);
            #1;
            host_op(1'b0, base, 32'h0, lat);
            chk("rnd_rd_lat", lat, 1);
        end

        // Reset asserted in the ACK cycle.
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
        @(posedge clk);
        #1;
        chk("rst_mid_ack_seen", {31'h0, host_ack}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_mid_ack_drop", {31'h0, host_ack}, 32'h0);
        chk("rst_mid_rdata", host_rdata, 32'h0);
        chk("rst_mid_misalign", {31'h0, misalign_err}, 32'h0);
        host_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        host_op(1'b0, 32'h10, 32'h0, lat);
        chk("post_rst_rd_lat", lat, 1);
        chk("post_rst_rdata_const", mdl[widx(32'h10)], 32'h8765_55A1);

        // tohost address: register with the feature, wrapped memory without.
        host_op(1'b1, 32'h3FF0, 32'hA5A5_A5A5, lat);
        core_store(3'b010, TOHOST, 32'h0000_0001);
        chk("tohost_value", tohost, TOHOST_EN ? 32'h1 : 32'h0);
        chk("tohost_valid_pulse", {31'h0, tohost_valid}, TOHOST_EN ? 32'h1 : 32'h0);
        @(posedge clk);
        #1;
        chk("tohost_valid_drop", {31'h0, tohost_valid}, 32'h0);
        core_load("tohost_core_rd", 3'b010, TOHOST, TOHOST_EN ? 32'h1 : 32'h1);
        @(posedge clk);
        #1;
        host_op(1'b0, 32'h3FF0, 32'h0, lat);
        chk("tohost_wrap_word", mdl[widx(32'h3FF0)], TOHOST_EN ? 32'hA5A5_A5A5 : 32'h1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the core's MEM-stage load/store interface. Core load data returns combinationally in the same cycle, and core stores commit on the clock edge. Load data is lane-extracted and sign/zero-extended per func3; store data is lane-placed with byte enables. A second host port lets the testbench or boot loader preload and inspect memory through a req/ack handshake, arbitrated against core stores.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words; power of two
AW, $clog2(DEPTH_WORDS), word-index width
TOHOST_ADDR, 32'h0000_FFF0, byte address of the tohost register (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
dmem_addr  in  32  core byte address (ALUout_MEM)
dmem_dataOUT  in  32  core store data (raw rs2, low bits significant)
func3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
memW_en_MEM  in  1  core store enable
dmem_dataIN  out  32  core load data, combinational
host_req  in  1  host access request; held until host_ack
host_we  in  1  1 = word write, 0 = word read
host_addr  in  32  host byte address; bits [1:0] ignored
host_wdata  in  32  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  32  host read data; valid while host_ack = 1
misalign_err  out  1  sticky flag: misaligned core store seen
tohost  out  32  last tohost value (optional feature)
tohost_valid  out  1  one-cycle pulse on tohost write (optional feature)

Behaviour:
- Word index = addr[AW+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Array has no reset; contents are undefined until written.
- Core read is combinational every cycle; there is no read enable. The word is fetched at the index, then the lane is selected:
  - B/BU: byte addr[1:0].
  - H/HU: halfword addr[1].
  - W: full word.
  - B/H sign-extend; BU/HU zero-extend.
  - func3 011/110/111 return the full word.
- Core store commits at posedge when memW_en_MEM = 1. Lane placement:
  - SB: dmem_dataOUT[7:0] to byte addr[1:0], one byte enable.
  - SH: [15:0] to half addr[1], two byte enables.
  - SW: all four bytes.
- Read-during-write: dmem_dataIN shows the old contents in the store cycle and the new value from the next cycle.
- Misaligned store (SH with addr[0] = 1, or SW with addr[1:0] != 0):
  - The write is suppressed.
  - misalign_err sets and holds until reset.
  - Loads are never checked, because func3 is garbage on non-load cycles.
- Host FSM states: IDLE, ACK.
  - In IDLE with host_req = 1 and no core store this cycle: perform the access and go to ACK.
    - Write: commit host_wdata to the word at posedge.
    - Read: register the word into host_rdata.
  - If a core store is present the same cycle, the core wins and the host stays in IDLE (retries next cycle). There is no starvation bound; the core rarely stores back-to-back.
  - ACK: host_ack = 1 for exactly one cycle, host_rdata held, return to IDLE. The host must drop or change host_req after the ack.
  - A new request is accepted at the earliest one cycle after ACK, i.e. one access per 2 cycles.
  - Host read of a word written by the core in the same cycle is not possible (core wins).
- Reset (async, any time, including mid-handshake):
  - FSM returns to IDLE.
  - host_ack = 0, host_rdata = 0, misalign_err = 0, tohost = 0, tohost_valid = 0.
  - An in-flight host access is dropped without ack; a write already clocked stays in the array.

Optional Feature:
- DMEM_TOHOST_EN defined:
  - A core SW with full 32-bit dmem_addr == TOHOST_ADDR loads tohost and pulses tohost_valid for one cycle.
  - The array is not written.
  - Core reads of that address return tohost.
- Not defined:
  - TOHOST_ADDR is ordinary (wrapped) memory.
  - tohost and tohost_valid are tied to 0.

Test Plan:
- Host write 0x8765_43A1 to 0x10 (ack after 1 cycle) -> core reads at 0x10:
  - LW gives 0x8765_43A1.
  - LB gives 0xFFFF_FFA1.
  - LBU at 0x13 gives 0x0000_0087.
  - LH at 0x12 gives 0xFFFF_8765.
- Core SB 0x55 at 0x11 onto 0x8765_43A1 -> word becomes 0x8765_55A1 next cycle; the same cycle still reads the old word.
- host_req read of 0x20 in the same cycle as a core SW to 0x24 -> core write lands, and host_ack arrives one cycle later than uncontended (2 cycles after req).
- Core SW 0x1234 at 0x22 -> no array change, and misalign_err = 1 persisting until rst low.
- Assert rst during ACK -> host_ack drops immediately; after release, a new host read of 0x10 returns 0x8765_55A1.
- DMEM_TOHOST_EN: core SW 0x1 at 0xFFF0 -> tohost = 0x1, tohost_valid pulses for 1 cycle, and the array word at index 0xFFF0 wrap is unchanged.
